// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy 10/5 refund payout with hopper inventory tracking.
// Optional CHANGE_STATS_EN adds coins_paid and short_events counters.
`timescale 1ns/1ps
module change_dispenser #(
    parameter int AMT_W      = 4,
    parameter int INV_W      = 6,
    parameter int INV_INIT10 = 8,
    parameter int INV_INIT5  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    output logic [1:0]       coin_out,
    output logic             coin_valid,
    input  logic             coin_ack,
    input  logic             refill10,
    input  logic             refill5,
    output logic [INV_W-1:0] inv10,
    output logic [INV_W-1:0] inv5,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remaining
`ifdef CHANGE_STATS_EN
    ,
    output logic [15:0]      coins_paid,
    output logic [7:0]       short_events
`endif
);

    typedef enum logic [1:0] {IDLE, SELECT, ISSUE, DONE} state_t;

    localparam logic [1:0]       COIN10  = 2'b10;
    localparam logic [1:0]       COIN5   = 2'b01;
    localparam logic [INV_W-1:0] INV_MAX = {INV_W{1'b1}};

    state_t           state;
    logic [AMT_W-1:0] rem;
    logic [AMT_W-1:0] rem_next;
    logic             paid;
    logic             pay10;
    logic             pay5;

    assign req_ready  = (state == IDLE);
    assign coin_valid = (state == ISSUE);
    assign done       = (state == DONE);

    assign paid     = (state == ISSUE) && coin_ack;
    assign pay10    = paid && (coin_out == COIN10);
    assign pay5     = paid && (coin_out == COIN5);
    assign rem_next = rem - ((coin_out == COIN10) ? AMT_W'(2) : AMT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rem       <= '0;
            coin_out  <= 2'b00;
            short     <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        short     <= 1'b0;
                        remaining <= '0;
                        if (req_amount == '0) begin
                            state <= DONE;
                        end else begin
                            rem   <= req_amount;
                            state <= SELECT;
                        end
                    end
                end
                SELECT: begin
                    // Tens first; a missing ten falls back to paying in fives.
                    if (rem >= AMT_W'(2) && inv10 != '0) begin
                        coin_out <= COIN10;
                        state    <= ISSUE;
                    end else if (rem != '0 && inv5 != '0) begin
                        coin_out <= COIN5;
                        state    <= ISSUE;
                    end else begin
                        short     <= 1'b1;
                        remaining <= rem;
                        state     <= DONE;
                    end
                end
                ISSUE: begin
                    if (coin_ack) begin
                        coin_out <= 2'b00;
                        rem      <= rem_next;
                        state    <= (rem_next == '0) ? DONE : SELECT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A refill coinciding with a dispense of the same coin leaves the count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inv10 <= INV_W'(INV_INIT10);
            inv5  <= INV_W'(INV_INIT5);
        end else begin
            if (pay10 && !refill10)
                inv10 <= inv10 - 1'b1;
            else if (refill10 && !pay10 && inv10 != INV_MAX)
                inv10 <= inv10 + 1'b1;

            if (pay5 && !refill5)
                inv5 <= inv5 - 1'b1;
            else if (refill5 && !pay5 && inv5 != INV_MAX)
                inv5 <= inv5 + 1'b1;
        end
    end

`ifdef CHANGE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coins_paid   <= '0;
            short_events <= '0;
        end else begin
            if (paid)
                coins_paid <= coins_paid + 16'd1;
            if (done && short && short_events != 8'hFF)
                short_events <= short_events + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - self-checking bench for change_dispenser.
`timescale 1ns/1ps
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [3:0] req_amount = 4'd0;
    logic       req_ready;
    logic [1:0] coin_out;
    logic       coin_valid;
    logic       coin_ack = 1'b0;
    logic       refill10 = 1'b0;
    logic       refill5 = 1'b0;
    logic [5:0] inv10;
    logic [5:0] inv5;
    logic       done;
    logic       short;
    logic [3:0] remaining;

    int checks = 0;
    int errors = 0;
    int m10 = 8;
    int m5 = 8;
    logic [1:0] coins[$];
    logic [1:0] exp_coins[$];

    change_dispenser dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_amount(req_amount),
        .req_ready(req_ready), .coin_out(coin_out), .coin_valid(coin_valid),
        .coin_ack(coin_ack), .refill10(refill10), .refill5(refill5),
        .inv10(inv10), .inv5(inv5), .done(done), .short(short), .remaining(remaining)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: greedy payout reduces to "as many tens as fit, then fives".
    task automatic run_req(input int amt, input int stall, input bit refill_ack, input string name);
        int n10, n5, r, exp_rem, k, first_k, wait_cnt;
        bit got_done;
        logic [1:0] held;
        n10 = amt / 2;
        if (n10 > m10) n10 = m10;
        r = amt - 2 * n10;
        n5 = (r < m5) ? r : m5;
        exp_rem = r - n5;
        exp_coins.delete();
        coins.delete();
        repeat (n10) exp_coins.push_back(2'b10);
        repeat (n5) exp_coins.push_back(2'b01);
        held = 2'b00;

        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL %s req_ready got %b want 1", name, req_ready);
        end
        req_valid = 1'b1;
        req_amount = amt[3:0];
        step();
        req_valid = 1'b0;

        k = 1; first_k = -1; wait_cnt = 0; got_done = 1'b0;
        while (!got_done && k < 400) begin
            if (done === 1'b1) begin
                got_done = 1'b1;
            end else begin
                if (coin_valid === 1'b1) begin
                    if (first_k < 0) first_k = k;
                    if (wait_cnt == 0) held = coin_out;
                    else begin
                        checks++;
                        if (coin_out !== held) begin
                            errors++; $display("FAIL %s coin_stable got %b want %b", name, coin_out, held);
                        end
                    end
                    if (wait_cnt >= stall) begin
                        coin_ack = 1'b1;
                        coins.push_back(coin_out);
                        if (refill_ack && coin_out == 2'b10) refill10 = 1'b1;
                        wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    checks++;
                    if (coin_out !== 2'b00) begin
                        errors++; $display("FAIL %s coin_out_idle got %b want 00", name, coin_out);
                    end
                end
                step();
                coin_ack = 1'b0;
                refill10 = 1'b0;
                k++;
            end
        end

        m10 = m10 - n10 + (refill_ack ? n10 : 0);
        m5 = m5 - n5;

        checks++;
        if (!got_done) begin
            errors++; $display("FAIL %s done_timeout got 0 want 1", name);
        end
        if (amt == 0) begin
            checks++;
            if (k != 1) begin
                errors++; $display("FAIL %s zero_latency got %0d want 1", name, k);
            end
        end else if (n10 + n5 > 0) begin
            checks++;
            if (first_k != 2) begin
                errors++; $display("FAIL %s first_coin_latency got %0d want 2", name, first_k);
            end
        end
        checks++;
        if (coins.size() != exp_coins.size()) begin
            errors++; $display("FAIL %s coin_count got %0d want %0d", name, coins.size(), exp_coins.size());
        end else begin
            foreach (exp_coins[i]) begin
                checks++;
                if (coins[i] !== exp_coins[i]) begin
                    errors++; $display("FAIL %s coin[%0d] got %b want %b", name, i, coins[i], exp_coins[i]);
                end
            end
        end
        checks++;
        if (short !== (exp_rem != 0)) begin
            errors++; $display("FAIL %s short got %b want %b", name, short, exp_rem != 0);
        end
        checks++;
        if (remaining !== 4'(exp_rem)) begin
            errors++; $display("FAIL %s remaining got %0d want %0d", name, remaining, exp_rem);
        end
        checks++;
        if (inv10 !== 6'(m10) || inv5 !== 6'(m5)) begin
            errors++; $display("FAIL %s inventory got %0d/%0d want %0d/%0d", name, inv10, inv5, m10, m5);
        end
        step();
        checks++;
        if (done !== 1'b0 || short !== (exp_rem != 0) || req_ready !== 1'b1) begin
            errors++; $display("FAIL %s after_done done=%b short=%b ready=%b want 0/%b/1",
                               name, done, short, req_ready, exp_rem != 0);
        end
    endtask

    task automatic pulse_refill(input bit r10, input bit r5);
        refill10 = r10;
        refill5 = r5;
        step();
        refill10 = 1'b0;
        refill5 = 1'b0;
        if (r10 && m10 < 63) m10++;
        if (r5 && m5 < 63) m5++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (coin_valid !== 1'b0 || coin_out !== 2'b00 || done !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got valid=%b out=%b done=%b want 0/00/0", coin_valid, coin_out, done);
        end
        checks++;
        if (short !== 1'b0 || remaining !== 4'd0) begin
            errors++; $display("FAIL reset_status got short=%b rem=%0d want 0/0", short, remaining);
        end
        checks++;
        if (inv10 !== 6'd8 || inv5 !== 6'd8) begin
            errors++; $display("FAIL reset_inventory got %0d/%0d want 8/8", inv10, inv5);
        end
        reset = 1'b0;
        m10 = 8; m5 = 8;
        step();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b want 1", req_ready);
        end
    endtask

    task automatic test_refill();
        repeat (3) pulse_refill(1'b1, 1'b0);
        repeat (70) pulse_refill(1'b0, 1'b1);
        checks++;
        if (inv10 !== 6'(m10) || inv5 !== 6'd63) begin
            errors++; $display("FAIL refill_saturate got %0d/%0d want %0d/63", inv10, inv5, m10);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        req_valid = 1'b1;
        req_amount = 4'd4;
        step();
        req_valid = 1'b0;
        k = 0;
        while (coin_valid !== 1'b1 && k < 10) begin
            step();
            k++;
        end
        checks++;
        if (coin_valid !== 1'b1) begin
            errors++; $display("FAIL reset_mid_issue got %b want 1", coin_valid);
        end
        repeat (2) step();
        reset = 1'b1;
        #1;
        checks++;
        if (coin_valid !== 1'b0 || coin_out !== 2'b00) begin
            errors++; $display("FAIL reset_mid_valid got %b/%b want 0/00", coin_valid, coin_out);
        end
        checks++;
        if (inv10 !== 6'd8 || inv5 !== 6'd8) begin
            errors++; $display("FAIL reset_mid_inventory got %0d/%0d want 8/8", inv10, inv5);
        end
        step();
        reset = 1'b0;
        m10 = 8; m5 = 8;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (done !== 1'b0) begin
                errors++; $display("FAIL reset_mid_no_done got %b want 0", done);
            end
            step();
        end
    endtask

    task automatic test_random();
        int amt, n;
        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 4);
            repeat (n) pulse_refill(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            amt = $urandom_range(0, 15);
            run_req(amt, $urandom_range(0, 2), 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        run_req(4, 0, 1'b0, "basic_4");
        run_req(3, 0, 1'b0, "mixed_3");
        run_req(10, 0, 1'b0, "drain_tens");
        run_req(4, 0, 1'b0, "no_tens_4");
        run_req(2, 0, 1'b0, "drain_fives");
        run_req(3, 0, 1'b0, "short_3");
        run_req(0, 0, 1'b0, "zero");
        test_refill();
        run_req(3, 5, 1'b0, "ack_stall");
        run_req(2, 0, 1'b1, "refill_same_cycle");
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
